// File: rtl/serial_add_sub_ctrl_if.sv
// Operand/result handshake bundle for the bit-serial adder/subtractor.
// The slave modport is the arithmetic block; the master modport is the operand source and result sink.
interface serial_add_sub_ctrl_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             carry_out;
   logic             overflow;
   logic             busy;

   modport slave (
      input  in_valid,
      input  op_a,
      input  op_b,
      input  sub,
      input  out_ready,
      output in_ready,
      output out_valid,
      output result,
      output carry_out,
      output overflow,
      output busy
   );

   modport master (
      output in_valid,
      output op_a,
      output op_b,
      output sub,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  result,
      input  carry_out,
      input  overflow,
      input  busy
   );
endinterface

// File: rtl/serial_add_sub_ctrl.sv
// Bit-serial adder/subtractor: one full-adder cell (two half adders + OR) stepped across WIDTH bits,
// with a valid/ready operand intake and a held valid/ready result.
module serial_add_sub_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   serial_add_sub_ctrl_if.slave   io_bus
);

   localparam int IDX_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   // {carry, sum}
   function automatic logic [1:0] half_add(input logic a, input logic b);
      return {a & b, a ^ b};
   endfunction

   state_t           r_state;
   state_t           w_next_state;

   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_res;
   logic             r_carry;
   logic [IDX_W-1:0] r_idx;
   logic             r_msb_cin;
   logic             r_carry_out;

   logic [1:0]       w_ha1;
   logic [1:0]       w_ha2;
   logic             w_sum;
   logic             w_cout;
   logic             w_accept;
   logic             w_last_bit;

   // Full-adder cell built from two half adders.
   always_comb begin
      w_ha1  = half_add(r_a[0], r_b[0]);
      w_ha2  = half_add(w_ha1[0], r_carry);
      w_sum  = w_ha2[0];
      w_cout = w_ha1[1] | w_ha2[1];
   end

   assign w_accept   = (r_state == S_IDLE) && io_bus.in_valid;
   assign w_last_bit = (r_idx == LAST_IDX);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      w_next_state = r_state;
      unique case (r_state)
         S_IDLE: if (io_bus.in_valid)  w_next_state = S_RUN;
         S_RUN:  if (w_last_bit)       w_next_state = S_HOLD;
         S_HOLD: if (io_bus.out_ready) w_next_state = S_IDLE;
         default:                      w_next_state = S_IDLE;
      endcase
   end

   always_comb begin
      io_bus.in_ready  = 1'b0;
      io_bus.out_valid = 1'b0;
      io_bus.busy      = 1'b0;
      unique case (r_state)
         S_IDLE: io_bus.in_ready = 1'b1;
         S_RUN:  io_bus.busy     = 1'b1;
         S_HOLD: begin
            io_bus.out_valid = 1'b1;
            io_bus.busy      = 1'b1;
         end
         default: io_bus.in_ready = 1'b0;
      endcase
   end

   // NOTE: the datapath registers are reset too, since result/carry/overflow must read 0 after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a         <= '0;
         r_b         <= '0;
         r_res       <= '0;
         r_carry     <= 1'b0;
         r_idx       <= '0;
         r_msb_cin   <= 1'b0;
         r_carry_out <= 1'b0;
      end else if (w_accept) begin
         // Subtraction is A + ~B + 1: invert B and preload the carry.
         r_a         <= io_bus.op_a;
         r_b         <= io_bus.sub ? ~io_bus.op_b : io_bus.op_b;
         r_carry     <= io_bus.sub;
         r_idx       <= '0;
         r_res       <= '0;
         r_msb_cin   <= 1'b0;
         r_carry_out <= 1'b0;
      end else if (r_state == S_RUN) begin
         r_res   <= {w_sum, r_res[WIDTH-1:1]};
         r_a     <= r_a >> 1;
         r_b     <= r_b >> 1;
         r_carry <= w_cout;
         r_idx   <= r_idx + IDX_W'(1);
         if (w_last_bit) begin
            r_msb_cin   <= r_carry;
            r_carry_out <= w_cout;
         end
      end
   end

   assign io_bus.result    = r_res;
   assign io_bus.carry_out = r_carry_out;
   assign io_bus.overflow  = r_msb_cin ^ r_carry_out;

endmodule
